// File: rtl/axi4_lite_csr_bank.sv
// AXI4-Lite CSR bank with per-register RW/RO/W1C/W1P access modes.
// AW and W are buffered independently; one write and one read may be in flight concurrently.
module axi4_lite_csr_bank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_OF_REGISTERS   = 16,
  parameter int C_S_AXI_ADDR_WIDTH = $clog2(NUM_OF_REGISTERS * (C_S_AXI_DATA_WIDTH / 8))
                                     + ((NUM_OF_REGISTERS == 1) ? 1 : 0),
  parameter logic [2*NUM_OF_REGISTERS-1:0] REG_MODE = '0
) (
  input  logic                                           S_AXI_ACLK,
  input  logic                                           S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
  input  logic [2:0]                                     S_AXI_AWPROT,
  input  logic                                           S_AXI_AWVALID,
  output logic                                           S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                S_AXI_WSTRB,
  input  logic                                           S_AXI_WVALID,
  output logic                                           S_AXI_WREADY,
  output logic [1:0]                                     S_AXI_BRESP,
  output logic                                           S_AXI_BVALID,
  input  logic                                           S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
  input  logic [2:0]                                     S_AXI_ARPROT,
  input  logic                                           S_AXI_ARVALID,
  output logic                                           S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                  S_AXI_RDATA,
  output logic [1:0]                                     S_AXI_RRESP,
  output logic                                           S_AXI_RVALID,
  input  logic                                           S_AXI_RREADY,
  input  logic [C_S_AXI_DATA_WIDTH*NUM_OF_REGISTERS-1:0] init_val,
  input  logic [C_S_AXI_DATA_WIDTH*NUM_OF_REGISTERS-1:0] status_in,
  output logic [C_S_AXI_DATA_WIDTH*NUM_OF_REGISTERS-1:0] val,
  output logic [NUM_OF_REGISTERS-1:0]                    wr_pulse,
  output logic [NUM_OF_REGISTERS-1:0]                    rd_pulse
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int NUM      = NUM_OF_REGISTERS;
  localparam int SW       = DW / 8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

  localparam logic [1:0] MODE_RO     = 2'd1;
  localparam logic [1:0] MODE_W1C    = 2'd2;
  localparam logic [1:0] MODE_W1P    = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic             ready_en_reg;
  logic             aw_full_reg;
  logic [IDX_W-1:0] aw_idx_reg;
  logic             w_full_reg;
  logic [DW-1:0]    wdata_reg;
  logic [SW-1:0]    wstrb_reg;
  logic             bvalid_reg;
  logic [1:0]       bresp_reg;
  logic             rvalid_reg;
  logic [1:0]       rresp_reg;
  logic [DW-1:0]    rdata_reg;
  logic [NUM-1:0]   wr_pulse_reg;
  logic [NUM-1:0]   rd_pulse_reg;

  logic             aw_hs, w_hs, ar_hs, commit;
  logic             aw_in_range, ar_in_range;
  logic [IDX_W-1:0] ar_idx;
  logic [DW-1:0]    wmask;
  logic [DW-1:0]    rd_value;
  logic [NUM-1:0]   wr_sel, rd_sel;
  logic [DW*NUM-1:0] rd_word;
  logic             unused_bits;

  assign S_AXI_AWREADY = ready_en_reg & ~aw_full_reg & ~bvalid_reg;
  assign S_AXI_WREADY  = ready_en_reg & ~w_full_reg & ~bvalid_reg;
  assign S_AXI_ARREADY = ready_en_reg & ~rvalid_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign wr_pulse      = wr_pulse_reg;
  assign rd_pulse      = rd_pulse_reg;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_full_reg & w_full_reg;

  assign ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign aw_in_range = int'(aw_idx_reg) < NUM;
  assign ar_in_range = int'(ar_idx) < NUM;

  assign unused_bits = ^{init_val, status_in, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{wstrb_reg[gi]}};
    end
  endgenerate

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ready_en_reg <= 1'b0;
      aw_full_reg  <= 1'b0;
      aw_idx_reg   <= '0;
      w_full_reg   <= 1'b0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rdata_reg    <= '0;
      wr_pulse_reg <= '0;
      rd_pulse_reg <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      wr_pulse_reg <= wr_sel;
      rd_pulse_reg <= rd_sel;
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_idx_reg  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_full_reg <= 1'b1;
        wdata_reg  <= S_AXI_WDATA;
        wstrb_reg  <= S_AXI_WSTRB;
      end
      if (bvalid_reg && S_AXI_BREADY) begin
        bvalid_reg <= 1'b0;
      end
      // Holders can only both be full while no B is pending, so commit never collides with a B handshake.
      if (commit) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end
      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_value;
        rresp_reg  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_reg && S_AXI_RREADY) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  // Out-of-range indices match no entry, so the read value falls back to zero.
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < NUM; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_value = rd_word[i*DW +: DW];
      end
    end
  end

  generate
    for (gi = 0; gi < NUM; gi++) begin : g_reg
      localparam logic [1:0] MODE = REG_MODE[2*gi +: 2];

      assign wr_sel[gi] = commit & aw_in_range & (aw_idx_reg == IDX_W'(gi));
      assign rd_sel[gi] = ar_hs & ar_in_range & (ar_idx == IDX_W'(gi));

      if (MODE == MODE_RO) begin : g_ro
        assign val[gi*DW +: DW]     = '0;
        assign rd_word[gi*DW +: DW] = status_in[gi*DW +: DW];
      end else if (MODE == MODE_W1P) begin : g_w1p
        logic [DW-1:0] pulse_reg;
        always_ff @(posedge S_AXI_ACLK) begin
          if (S_AXI_ARESET) begin
            pulse_reg <= '0;
          end else begin
            pulse_reg <= wr_sel[gi] ? (wdata_reg & wmask) : '0;
          end
        end
        assign val[gi*DW +: DW]     = pulse_reg;
        assign rd_word[gi*DW +: DW] = '0;
      end else begin : g_store
        logic [DW-1:0] data_reg;
        logic [DW-1:0] data_next;
        // For W1C the status OR is applied after the clear so a coincident set wins.
        always_comb begin
          data_next = data_reg;
          if (MODE == MODE_W1C) begin
            if (wr_sel[gi]) begin
              data_next = data_reg & ~(wdata_reg & wmask);
            end
            data_next = data_next | status_in[gi*DW +: DW];
          end else if (wr_sel[gi]) begin
            data_next = (data_reg & ~wmask) | (wdata_reg & wmask);
          end
        end
        always_ff @(posedge S_AXI_ACLK) begin
          if (S_AXI_ARESET) begin
            data_reg <= init_val[gi*DW +: DW];
          end else begin
            data_reg <= data_next;
          end
        end
        assign val[gi*DW +: DW]     = data_reg;
        assign rd_word[gi*DW +: DW] = data_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_axi4_lite_csr_bank.sv
// Directed bench for axi4_lite_csr_bank: five registers (RW, RW, W1C, W1P, RO),
// B/R responses checked through expectation queues.
module tb_axi4_lite_csr_bank;
  localparam int DW  = 32;
  localparam int NUM = 5;
  localparam int AW  = 5;
  localparam logic [2*NUM-1:0] MODES = {2'd1, 2'd3, 2'd2, 2'd0, 2'd0};

  logic              clk = 1'b0;
  logic              srst;
  logic [AW-1:0]     awaddr, araddr;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DW-1:0]     wdata, rdata;
  logic [DW/8-1:0]   wstrb;
  logic [1:0]        bresp, rresp;
  logic [DW*NUM-1:0] init_val, status_in, val;
  logic [NUM-1:0]    wr_pulse, rd_pulse;

  int total = 0;
  int bad   = 0;
  logic [1:0]  b_q[$];
  logic [33:0] r_q[$];

  always #5 clk = ~clk;

  axi4_lite_csr_bank #(
    .C_S_AXI_DATA_WIDTH(DW), .NUM_OF_REGISTERS(NUM), .C_S_AXI_ADDR_WIDTH(AW), .REG_MODE(MODES)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(srst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .init_val(init_val), .status_in(status_in), .val(val),
    .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW*NUM-1:0] obs, input logic [DW*NUM-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_aw_w(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int n = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      tick();
      n++;
      if (aw_now) begin awvalid = 1'b0; aw_done = 1; end
      if (w_now)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    chk("aw_w_accept_timeout", 160'(n < 20), 160'(1));
  endtask

  task automatic wait_b();
    int n = 0;
    logic [1:0] exp;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("b_timeout", 160'(n < 20), 160'(1));
    exp = (b_q.size() > 0) ? b_q.pop_front() : 2'bxx;
    chk("bresp", 160'(bresp), 160'(exp));
    bready = 1'b1;
    tick();
    chk("bvalid_clear", 160'(bvalid), 160'(0));
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp);
    b_q.push_back(exp_resp);
    send_aw_w(addr, data, strb);
    wait_b();
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data, input logic [1:0] exp_resp,
                         input logic [NUM-1:0] exp_rdp);
    int n = 0;
    logic [33:0] exp;
    r_q.push_back({exp_resp, exp_data});
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    while (!rvalid && n < 40) begin tick(); n++; end
    chk("r_timeout", 160'(n < 40), 160'(1));
    exp = (r_q.size() > 0) ? r_q.pop_front() : 34'bx;
    chk("rdata", 160'(rdata), 160'(exp[31:0]));
    chk("rresp", 160'(rresp), 160'(exp[33:32]));
    chk("rd_pulse", 160'(rd_pulse), 160'(exp_rdp));
    $display("read addr=%h rdata=%h rresp=%0d rd_pulse=%b", addr, rdata, rresp, rd_pulse);
    tick();
    chk("rd_pulse_clear", 160'(rd_pulse), 160'(0));
  endtask

  initial begin
    srst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b0; rready = 1'b1;
    status_in = '0;
    init_val = '0;
    init_val[31:0] = 32'h1234_5678;
    repeat (3) tick();

    // Reset state
    chk("reset_readies", 160'({awready, wready, arready}), 160'(0));
    chk("reset_valids", 160'({bvalid, rvalid, bresp, rresp}), 160'(0));
    chk("reset_rdata", 160'(rdata), 160'(0));
    chk("reset_val", val, {128'h0, 32'h1234_5678});
    chk("reset_pulses", 160'({wr_pulse, rd_pulse}), 160'(0));
    srst = 1'b0;
    tick();
    chk("ready_after_reset", 160'({awready, wready, arready}), 160'(3'b111));
    do_read(5'h00, 32'h1234_5678, 2'b00, 5'b00001);

    // W ahead of AW, partial strobe into RW reg1
    wdata = 32'hDEAD_BEEF; wstrb = 4'b0011; wvalid = 1'b1;
    chk("w_ready_first", 160'(wready), 160'(1));
    b_q.push_back(2'b00);
    tick();
    wvalid = 1'b0;
    chk("w_held_ready", 160'({awready, wready}), 160'(2'b10));
    tick();
    awaddr = 5'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("b_not_yet", 160'(bvalid), 160'(0));
    tick();
    chk("b_after_commit", 160'(bvalid), 160'(1));
    chk("wr_pulse_reg1", 160'(wr_pulse), 160'(5'b00010));
    chk("reg1_partial", 160'(val[63:32]), 160'(32'h0000_BEEF));
    $display("write W-before-AW reg1 val=%h wr_pulse=%b", val[63:32], wr_pulse);
    wait_b();
    chk("wr_pulse_one_cycle", 160'(wr_pulse), 160'(0));

    // W1C reg2: set by status, set-wins over clear, then clear
    status_in[67] = 1'b1;
    tick();
    status_in[67] = 1'b0;
    tick();
    chk("w1c_set", 160'(val[95:64]), 160'(32'h8));
    status_in[67] = 1'b1;
    do_write(5'h08, 32'h8, 4'hF, 2'b00);
    chk("w1c_set_wins", 160'(val[95:64]), 160'(32'h8));
    $display("write W1C reg2 with status held val=%h", val[95:64]);
    status_in[67] = 1'b0;
    do_write(5'h08, 32'h8, 4'hF, 2'b00);
    chk("w1c_cleared", 160'(val[95:64]), 160'(32'h0));
    do_read(5'h08, 32'h0, 2'b00, 5'b00100);

    // W1P reg3: one-cycle pulse
    b_q.push_back(2'b00);
    bready = 1'b1;
    send_aw_w(5'h0C, 32'h5, 4'hF);
    chk("w1p_before_commit", 160'(val[127:96]), 160'(0));
    tick();
    chk("w1p_pulse", 160'(val[127:96]), 160'(32'h5));
    chk("w1p_wr_pulse", 160'(wr_pulse), 160'(5'b01000));
    $display("write W1P reg3 pulse=%h", val[127:96]);
    wait_b();
    chk("w1p_pulse_gone", 160'(val[127:96]), 160'(0));
    do_read(5'h0C, 32'h0, 2'b00, 5'b01000);

    // Out-of-range index 5 (byte address NUM*4)
    b_q.push_back(2'b10);
    send_aw_w(5'h14, 32'hFFFF_FFFF, 4'hF);
    tick();
    chk("oor_no_wr_pulse", 160'(wr_pulse), 160'(0));
    wait_b();
    $display("write out-of-range addr=14 bresp=%0d", bresp);
    chk("oor_no_change", val, {32'h0, 32'h0, 32'h0, 32'h0000_BEEF, 32'h1234_5678});
    do_read(5'h14, 32'h0, 2'b10, 5'b00000);

    // B back-pressure with a concurrent RO read
    bready = 1'b0;
    status_in[159:128] = 32'hA5A5_0001;
    b_q.push_back(2'b00);
    send_aw_w(5'h00, 32'h1111_2222, 4'hF);
    tick();
    chk("bp_stall_a", 160'({awready, wready, bvalid}), 160'(3'b001));
    do_read(5'h10, 32'hA5A5_0001, 2'b00, 5'b10000);
    chk("bp_stall_b", 160'({awready, wready, bvalid}), 160'(3'b001));
    awaddr = 5'h04; wdata = 32'h3333_4444; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    chk("bp_second_stalled", 160'({awready, wready, bvalid}), 160'(3'b001));
    chk("bp_reg1_unchanged", 160'(val[63:32]), 160'(32'h0000_BEEF));
    wait_b();
    $display("write reg0 released after back-pressure val=%h", val[31:0]);
    do_write(5'h04, 32'h3333_4444, 4'hF, 2'b00);
    do_read(5'h00, 32'h1111_2222, 2'b00, 5'b00001);
    do_read(5'h04, 32'h3333_4444, 2'b00, 5'b00010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
